toggle_rx: RTL and testbench
============================

# toggle_rx

Receive end of the two-phase toggle handshake whose transmit side is a T-flip-flop request toggle. Synchronises an asynchronous request toggle `req_t` into `clk`, converts each level change into one captured data word, presents it to a local consumer with valid/ready, and returns an acknowledge toggle `ack_t` once the word is consumed. Counts accepted events and flags protocol overruns. Sits at the destination side of any clock-domain crossing built on the team's toggle flops.

## Interface

- `SYNC_STAGES`, 2, synchroniser depth for `req_t` (legal ≥2)
- `DW`, 8, data word width
- `CW`, 8, event counter width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `req_t` in 1: request toggle from sender (asynchronous); every level change = one event
- `din` in DW: bundled data; sender holds it stable from its `req_t` toggle until it sees the matching `ack_t` toggle
- `rx_ready` in 1: consumer accepts `rx_data` when high with `rx_valid`
- `clr_ovf` in 1: synchronous clear of `ovf`
- `rx_valid` out 1: `rx_data` holds an unconsumed word
- `rx_data` out DW: captured word
- `ack_t` out 1: acknowledge toggle back to sender
- `evt_cnt` out CW: accepted-event count
- `ovf` out 1: sticky overrun flag

## Operation

- Synchroniser: `SYNC_STAGES` flops on `req_t`, then `req_prev` register. `tog = sync_out ^ req_prev`, high for exactly one cycle per `req_t` level change.
- FSM states: IDLE, HOLD.
  - IDLE: `rx_valid`=0. On `tog`: load `din` into `rx_data`, set `rx_valid`, increment `evt_cnt`, go to HOLD.
  - HOLD: `rx_valid`=1, `rx_data` frozen. On `rx_ready`: clear `rx_valid`, invert `ack_t`, go to IDLE.
  - `tog` in HOLD is a protocol violation, because the sender toggled before its ack. Set `ovf`. Do not overwrite `rx_data` and do not count the event. This holds even when `rx_ready` is high in the same cycle; the handshake still completes normally.
- `evt_cnt`: modulo 2^CW; wraps from all-ones to 0 without flagging.
- `ovf`: sticky.
  - Cleared by `clr_ovf`.
  - If a set and `clr_ovf` occur in the same cycle, the set wins.
- Reset (any time, including mid-handshake):
  - Sync chain, `req_prev`, `rx_valid`, `rx_data`, `ack_t`, `evt_cnt`, `ovf` all go to 0 immediately; FSM goes to IDLE.
  - An in-flight word is discarded.
  - If `req_t`=1 when `rst` releases, one event is detected after synchronisation. Sender and receiver must be reset together.

## Timing

- Latency from `req_t` change to `rx_valid`:
  - `req_t` changes before rising edge E0 (edge 0).
  - `tog` is high after edge `SYNC_STAGES-1`.
  - `rx_valid` goes high after edge `SYNC_STAGES`. With the default depth of 2, the edge is E2.
- Accept and acknowledge: if `rx_valid` and `rx_ready` are high at edge E, then `rx_valid` is 0 and `ack_t` has toggled after E.
- Back-to-back:
  - Minimum consumer-side spacing is one cycle in IDLE between words.
  - Overall throughput is bounded by the sender's ack round trip.
- `rx_data`, `rx_valid`, `ack_t` are registered outputs; no combinational path from inputs.

## Structure

- Package `toggle_pkg`: FSM state enum (IDLE, HOLD); default constants for `SYNC_STAGES`, `DW`, `CW`.
- Sub-module `toggle_sync`:
  - Parameterised `SYNC_STAGES` flop chain plus `req_prev`; outputs `tog`.
  - Async active-low reset to 0.
  - Reusable by any future toggle receiver.
- Top: FSM, data register, counter, overrun logic.

## Test plan

- Reset value and basic capture:
  - Hold `rst`=0 → all outputs 0.
  - Release, toggle `req_t` 0→1 with `din`=8'hA5, `rx_ready`=0.
  - Expect `rx_valid`=1, `rx_data`=A5, `evt_cnt`=1 after edge 2 (default depth).
  - Then `rx_ready`=1 → `rx_valid`=0 and `ack_t`=1 next edge.
- Streaming:
  - Emulate a T-FF sender that toggles only after each `ack_t` change; send 20 random words with `rx_ready` always 1.
  - Expect every word in order, `evt_cnt`=20, `ovf`=0, `ack_t`=0 at end (even toggle count).
- Overrun:
  - In HOLD with `rx_data`=8'h11, toggle `req_t` again with `din`=8'h22 while `rx_ready`=0.
  - Expect `ovf`=1, `rx_data` still 11, `evt_cnt` unchanged.
  - Pulse `clr_ovf` → `ovf`=0.
  - Drive `clr_ovf`=1 in the same cycle as a new overrun → `ovf`=1.
- Counter wrap: with CW=8, deliver 256 events → `evt_cnt`=0, `ovf`=0.
- Reset mid-handshake:
  - Assert `rst` low while in HOLD with `rx_valid`=1 and `ack_t`=1 → all outputs 0 immediately, without waiting for a clock edge.
  - After release, resetting the sender too, the next `req_t` toggle is received normally with `evt_cnt`=1.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and default sizes for two-phase toggle receivers.
package toggle_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DW          = 8;
  localparam int DEF_CW          = 8;

endpackage

// File: rtl/toggle_sync.sv
// Synchronises an asynchronous request toggle and emits a one-cycle pulse per level change.
// Latency: pulse is high after edge SYNC_STAGES-1 from the change; no backpressure.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_t,
  output logic tog
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   req_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= '0;
      req_prev <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], req_t};
      req_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign tog = sync[SYNC_STAGES-1] ^ req_prev;

endmodule

// File: rtl/toggle_rx.sv
// Toggle-handshake receiver: captures din per req_t change, offers it on valid/ready, acks via ack_t.
// Latency: rx_valid high SYNC_STAGES edges after req_t change; word held until rx_ready, then ack toggles.
module toggle_rx
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DW          = DEF_DW,
  parameter int CW          = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_t,
  input  logic [DW-1:0] din,
  input  logic          rx_ready,
  input  logic          clr_ovf,
  output logic          rx_valid,
  output logic [DW-1:0] rx_data,
  output logic          ack_t,
  output logic [CW-1:0] evt_cnt,
  output logic          ovf
);

  state_t state;
  logic   tog;
  logic   ovf_set;

  toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .req_t (req_t),
    .tog   (tog)
  );

  // A toggle while a word is still held means the sender did not wait for its ack.
  assign ovf_set = tog && (state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      ack_t    <= 1'b0;
      evt_cnt  <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tog) begin
            rx_data  <= din;
            rx_valid <= 1'b1;
            evt_cnt  <= evt_cnt + 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            ack_t    <= ~ack_t;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_rx.sv
// Self-checking bench for toggle_rx: sender modelled as a T-flop that waits for each ack toggle.
module tb_toggle_rx;

  logic       clk;
  logic       rst;
  logic       req_t;
  logic [7:0] din;
  logic       rx_ready;
  logic       clr_ovf;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       ack_t;
  logic [7:0] evt_cnt;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  toggle_rx dut (
    .clk      (clk),
    .rst      (rst),
    .req_t    (req_t),
    .din      (din),
    .rx_ready (rx_ready),
    .clr_ovf  (clr_ovf),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .ack_t    (ack_t),
    .evt_cnt  (evt_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset both sides together and leave the receiver idle.
  task automatic do_reset();
    rst      = 1'b0;
    req_t    = 1'b0;
    din      = 8'h00;
    rx_ready = 1'b0;
    clr_ovf  = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  // Sender: present w, toggle req_t, wait for the ack toggle; reports the word seen consumed.
  task automatic send_word(input logic [7:0] w, output logic [7:0] got, output bit ok);
    logic prev_ack;
    got      = 8'hxx;
    prev_ack = ack_t;
    din      = w;
    req_t    = ~req_t;
    for (int c = 0; c < 30 && ack_t == prev_ack; c++) begin
      if (rx_valid && rx_ready) got = rx_data;
      step(1);
    end
    ok = (ack_t != prev_ack);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_t = 1'b0; din = 8'h00; rx_ready = 1'b0; clr_ovf = 1'b0;
    step(2);
    n_cmp++;
    if ({rx_valid, rx_data, ack_t, evt_cnt, ovf} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h ack=%b cnt=%0d ovf=%b, need all 0",
               rx_valid, rx_data, ack_t, evt_cnt, ovf);
    end
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    din = 8'hA5;
    req_t = 1'b1;
    step(2);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early_valid: rx_valid=%b after edge 1, need 0", rx_valid);
    end
    step(1);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || evt_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL basic_capture: valid=%b data=%h cnt=%0d, need 1 a5 1", rx_valid, rx_data, evt_cnt);
    end
    step(2);
    n_cmp++;
    if (rx_valid !== 1'b1 || ack_t !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_hold: valid=%b ack=%b, need 1 0", rx_valid, ack_t);
    end
    rx_ready = 1'b1;
    step(1);
    n_cmp++;
    if (rx_valid !== 1'b0 || ack_t !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_accept: valid=%b ack=%b, need 0 1", rx_valid, ack_t);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] w, got;
    bit ok;
    int bad_words;
    do_reset();
    rx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = 8'($urandom_range(0, 255));
      exp_q.push_back(w);
      send_word(w, got, ok);
      got_q.push_back(got);
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL stream_timeout: word %0d got no ack", i);
      end
    end
    bad_words = 0;
    for (int i = 0; i < 20; i++)
      if (got_q[i] !== exp_q[i]) bad_words++;
    n_cmp++;
    if (bad_words != 0) begin
      n_bad++;
      $display("FAIL stream_data: %0d words differ, need 0 (first got %h need %h)",
               bad_words, got_q[0], exp_q[0]);
    end
    n_cmp++;
    if (evt_cnt !== 8'd20 || ovf !== 1'b0 || ack_t !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_end: cnt=%0d ovf=%b ack=%b, need 20 0 0", evt_cnt, ovf, ack_t);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    din = 8'h11; req_t = ~req_t;
    step(4);
    din = 8'h22; req_t = ~req_t;
    step(4);
    n_cmp++;
    if (ovf !== 1'b1 || rx_data !== 8'h11 || evt_cnt !== 8'd1 || rx_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: ovf=%b data=%h cnt=%0d valid=%b, need 1 11 1 1",
               ovf, rx_data, evt_cnt, rx_valid);
    end
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clear: ovf=%b, need 0", ovf);
    end
    // Pulse is high after edge 1; clear is driven into edge 2 where the set lands.
    din = 8'h33; req_t = ~req_t;
    step(2);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set_wins: ovf=%b, need 1", ovf);
    end
    step(2);
    n_cmp++;
    if (ovf !== 1'b1 || rx_data !== 8'h11 || evt_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL overrun_sticky: ovf=%b data=%h cnt=%0d, need 1 11 1", ovf, rx_data, evt_cnt);
    end
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0 || ack_t !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_drain: valid=%b ack=%b, need 0 1", rx_valid, ack_t);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] w, got;
    bit ok;
    int bad_words, n_acc;
    do_reset();
    rx_ready = 1'b1;
    bad_words = 0;
    n_acc = 0;
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom_range(0, 255));
      send_word(w, got, ok);
      if (ok) n_acc++;
      if (!ok || got !== w) bad_words++;
    end
    n_cmp++;
    if (bad_words != 0) begin
      n_bad++;
      $display("FAIL wrap_data: %0d bad transfers, need 0", bad_words);
    end
    n_cmp++;
    if (evt_cnt !== 8'(n_acc % 256) || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_count: cnt=%0d ovf=%b, need %0d 0", evt_cnt, ovf, n_acc % 256);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    bit ok;
    do_reset();
    rx_ready = 1'b1;
    send_word(8'h5C, got, ok);
    rx_ready = 1'b0;
    din = 8'hC3; req_t = ~req_t;
    step(4);
    n_cmp++;
    if (rx_valid !== 1'b1 || ack_t !== 1'b1 || rx_data !== 8'hC3 || evt_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL midrst_setup: valid=%b ack=%b data=%h cnt=%0d, need 1 1 c3 2",
               rx_valid, ack_t, rx_data, evt_cnt);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({rx_valid, rx_data, ack_t, evt_cnt, ovf} !== 19'd0) begin
      n_bad++;
      $display("FAIL midrst_async: valid=%b data=%h ack=%b cnt=%0d ovf=%b, need all 0",
               rx_valid, rx_data, ack_t, evt_cnt, ovf);
    end
    req_t = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    rx_ready = 1'b1;
    send_word(8'h7E, got, ok);
    n_cmp++;
    if (!ok || got !== 8'h7E || evt_cnt !== 8'd1 || ack_t !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_after: ok=%b data=%h cnt=%0d ack=%b, need 1 7e 1 1",
               ok, got, evt_cnt, ack_t);
    end
    rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_overrun();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
